// File: rtl/bin_to_bcd_display.sv
`timescale 1ns/1ps
// bin_to_bcd_display
//   Iterative shift-add-3 binary-to-BCD converter. Each converted nibble and
//   its enable drive one hex 7-segment decoder (hex/oe). Leading zeros are
//   blanked through digit_oe. The converter sits between the CPU output
//   register and the display decoders.
//
//   Optional feature macro: BCD_SIGNED_EN
//     defined   : value is two's complement. The magnitude is converted and
//                 neg reports the sign.
//     undefined : value is unsigned and neg is always 0.
//
// Parameters
//   WIDTH   binary input width (>= 2)
//   DIGITS  number of BCD digits presented on the outputs
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   request a conversion of value (sampled only when idle)
//   value     in   binary operand, captured on the accepted start cycle
//   busy      out  conversion in progress
//   done      out  one-cycle pulse, new result valid
//   digits    out  BCD result, digit 0 in bits [3:0]
//   digit_oe  out  per-digit display enable (leading-zero blanking)
//   ovf       out  result needs more than DIGITS digits
//   neg       out  sign of the last result
module bin_to_bcd_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_oe,
    output logic                  ovf,
    output logic                  neg
);

    // log10(2) < 1/3, so WIDTH/3+1 decimal digits always hold 2^WIDTH-1.
    // The scratch register is never narrower than the output.
    localparam int NAT = WIDTH / 3 + 1;
    localparam int SCR = (NAT > DIGITS) ? NAT : DIGITS;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     bin_reg, bin_next;
    logic [4*SCR-1:0]     bcd_reg, bcd_next;
    logic [4*SCR-1:0]     bcd_adj;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 neg_pend_reg, neg_pend_next;
    logic                 commit;

    logic                 done_reg;
    logic [4*DIGITS-1:0]  digits_reg;
    logic [DIGITS-1:0]    oe_reg;
    logic                 ovf_reg;
    logic                 neg_reg;

    logic                 sign_in;
    logic [WIDTH-1:0]     mag_in;
    logic [DIGITS-1:0]    nz;
    logic [DIGITS-1:0]    oe_calc;
    logic                 ovf_calc;

    // Operand conditioning: only the magnitude enters the shift register.
    // For the most negative input, -value wraps to 2^(WIDTH-1). That value
    // is the correct unsigned magnitude.
`ifdef BCD_SIGNED_EN
    assign sign_in = value[WIDTH-1];
    assign mag_in  = value[WIDTH-1] ? (~value + 1'b1) : value;
`else
    assign sign_in = 1'b0;
    assign mag_in  = value;
`endif

    // Add-3 correction on every scratch nibble before it is doubled.
    generate
        for (genvar gi = 0; gi < SCR; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and scratch datapath
    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        cnt_next      = cnt_reg;
        neg_pend_next = neg_pend_reg;
        commit        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_next      = mag_in;
                    bcd_next      = '0;
                    cnt_next      = CW'(WIDTH);
                    neg_pend_next = sign_in;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_next = {bcd_adj[4*SCR-2:0], bin_reg[WIDTH-1]};
                bin_next = {bin_reg[WIDTH-2:0], 1'b0};
                cnt_next = cnt_reg - 1'b1;
                // The last shift lands the final result in bcd_next. It is
                // committed on the same edge, so done follows the last
                // busy cycle directly.
                if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                    commit     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Overflow: any scratch nibble above the presented digits is nonzero
    always_comb begin
        ovf_calc = 1'b0;
        for (int i = DIGITS; i < SCR; i++) begin
            ovf_calc = ovf_calc | (|bcd_next[4*i +: 4]);
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
            assign nz[gi] = |bcd_next[4*gi +: 4];
        end
    endgenerate

    // Leading-zero blanking: a digit is lit when it or any higher digit is
    // nonzero. Overflow lights everything. Digit 0 is always lit, so zero
    // still shows "0".
    always_comb begin
        logic seen;
        seen    = ovf_calc;
        oe_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen       = seen | nz[i];
            oe_calc[i] = seen;
        end
        oe_calc[0] = 1'b1;
    end

    // Scratch registers and committed outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            neg_pend_reg <= 1'b0;
            done_reg     <= 1'b0;
            digits_reg   <= '0;
            oe_reg       <= DIGITS'(1);
            ovf_reg      <= 1'b0;
            neg_reg      <= 1'b0;
        end else begin
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            cnt_reg      <= cnt_next;
            neg_pend_reg <= neg_pend_next;
            done_reg     <= commit;
            if (commit) begin
                digits_reg <= bcd_next[4*DIGITS-1:0];
                oe_reg     <= oe_calc;
                ovf_reg    <= ovf_calc;
                neg_reg    <= neg_pend_reg;
            end
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign done     = done_reg;
    assign digits   = digits_reg;
    assign digit_oe = oe_reg;
    assign ovf      = ovf_reg;
    assign neg      = neg_reg;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
`timescale 1ns/1ps
// Testbench for bin_to_bcd_display.
// Two instances share the stimulus: DIGITS=5 (full range) and DIGITS=4
// (overflow case). A decimal-arithmetic model predicts every output on every
// cycle. Directed literal checks pin the model.
module tb_bin_to_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] value;

    logic        busy, done, ovf, neg;
    logic [19:0] digits;
    logic [4:0]  digit_oe;
    logic        busy4, done4, ovf4, neg4;
    logic [15:0] digits4;
    logic [3:0]  digit_oe4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .digits(digits), .digit_oe(digit_oe),
        .ovf(ovf), .neg(neg)
    );

    bin_to_bcd_display #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy4), .done(done4), .digits(digits4), .digit_oe(digit_oe4),
        .ovf(ovf4), .neg(neg4)
    );

    // ---------------- behavioural model ----------------
    // Decimal expansion of the operand magnitude, using plain integer math.
    function automatic void model_conv(input logic [15:0] v, input int nd,
                                       output logic [19:0] d, output logic [4:0] oe,
                                       output logic ov, output logic ng);
        int unsigned mag;
        int unsigned p;
        int          top;
        int unsigned dg;
        ng  = 1'b0;
        mag = v;
`ifdef BCD_SIGNED_EN
        if (v[15]) begin
            ng  = 1'b1;
            mag = 32'd65536 - mag;
        end
`endif
        d   = '0;
        p   = 1;
        top = 0;
        for (int i = 0; i < nd; i++) begin
            dg = (mag / p) % 10;
            d[4*i +: 4] = 4'(dg);
            if (dg != 0) top = i;
            p = p * 10;
        end
        ov = (mag >= p);
        oe = '0;
        for (int i = 0; i < nd; i++) oe[i] = ov || (i <= top);
    endfunction

    logic [15:0] m_val;
    int          m_left;
    logic        m_busy, m_done, m_neg, m_ovf5, m_ovf4;
    logic [19:0] m_d5, m_d4;
    logic [4:0]  m_oe5, m_oe4;

    logic [19:0] e_d5, e_d4;
    logic [4:0]  e_oe5, e_oe4;
    logic        e_ov5, e_ov4, e_ng5, e_ng4;

    always_comb begin
        model_conv(m_val, 5, e_d5, e_oe5, e_ov5, e_ng5);
        model_conv(m_val, 4, e_d4, e_oe4, e_ov4, e_ng4);
    end

    // Timeline: an accepted start makes the design busy for 16 cycles. The
    // result and done appear together in the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_val  <= '0;
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_d5   <= '0;
            m_oe5  <= 5'b00001;
            m_ovf5 <= 1'b0;
            m_d4   <= '0;
            m_oe4  <= 5'b00001;
            m_ovf4 <= 1'b0;
            m_neg  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_d5   <= e_d5;
                    m_oe5  <= e_oe5;
                    m_ovf5 <= e_ov5;
                    m_d4   <= e_d4;
                    m_oe4  <= e_oe4;
                    m_ovf4 <= e_ov4;
                    m_neg  <= e_ng5;
                end
            end else if (start) begin
                m_val  <= value;
                m_left <= 16;
                m_busy <= 1'b1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (reset !== 1'bx) begin
            n_cmp++;
            if ({busy, done, digits, digit_oe, ovf, neg} !==
                {m_busy, m_done, m_d5, m_oe5, m_ovf5, m_neg}) begin
                n_bad++;
                $display("FAIL cyc5 t=%0t got busy=%b done=%b dig=%h oe=%b ovf=%b neg=%b want busy=%b done=%b dig=%h oe=%b ovf=%b neg=%b",
                         $time, busy, done, digits, digit_oe, ovf, neg,
                         m_busy, m_done, m_d5, m_oe5, m_ovf5, m_neg);
            end
            n_cmp++;
            if ({busy4, done4, digits4, digit_oe4, ovf4, neg4} !==
                {m_busy, m_done, m_d4[15:0], m_oe4[3:0], m_ovf4, m_neg}) begin
                n_bad++;
                $display("FAIL cyc4 t=%0t got busy=%b done=%b dig=%h oe=%b ovf=%b neg=%b want busy=%b done=%b dig=%h oe=%b ovf=%b neg=%b",
                         $time, busy4, done4, digits4, digit_oe4, ovf4, neg4,
                         m_busy, m_done, m_d4[15:0], m_oe4[3:0], m_ovf4, m_neg);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle number (start cycle = 0) at which done is seen and
    // the number of busy cycles observed before it.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 1;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", cyc);
        end
    endtask

    initial begin
        int c, nb, nd;
        reset = 1'b1;
        start = 1'b0;
        value = '0;

        // 1. reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h00000);
        check("rst_oe",     32'(digit_oe), 32'b00001);
        check("rst_flags",  32'({busy, done, ovf, neg}), 32'b0000);
        reset = 1'b0;

        // 2. 1234: latency and busy window
        do_start(16'd1234);
        wait_done(c, nb);
        $display("txn 1234: done at cycle %0d, busy %0d, digits=%h oe=%b", c, nb, digits, digit_oe);
        check("lat_1234",  32'(c), 32'd17);
        check("busy_1234", 32'(nb), 32'd16);
        check("dig_1234",  32'(digits), 32'h01234);
        check("oe_1234",   32'(digit_oe), 32'b01111);

        // 3. all-ones, then zero
        do_start(16'hFFFF);
        wait_done(c, nb);
        $display("txn FFFF: digits=%h oe=%b neg=%b", digits, digit_oe, neg);
`ifdef BCD_SIGNED_EN
        check("dig_ffff", 32'(digits), 32'h00001);
        check("neg_ffff", 32'(neg), 32'd1);
        check("oe_ffff",  32'(digit_oe), 32'b00001);
`else
        check("dig_ffff", 32'(digits), 32'h65535);
        check("neg_ffff", 32'(neg), 32'd0);
        check("oe_ffff",  32'(digit_oe), 32'b11111);
`endif
        do_start(16'd0);
        wait_done(c, nb);
        $display("txn 0: digits=%h oe=%b", digits, digit_oe);
        check("dig_0", 32'(digits), 32'h00000);
        check("oe_0",  32'(digit_oe), 32'b00001);

        // 4. start held high: conversions back to back every 17 cycles
        @(negedge clk);
        value = 16'd7;
        start = 1'b1;
        nd = 0;
        for (int i = 0; i < 51; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        start = 1'b0;
        $display("txn 7 held: %0d done pulses, digits=%h", nd, digits);
        check("held_dones", 32'(nd), 32'd3);
        check("held_dig",   32'(digits), 32'h00007);
        repeat (20) @(negedge clk);

        // 5. reset at cycle 8 of a conversion aborts it
        do_start(16'd999);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_dig",  32'(digits), 32'h00000);
        check("abort_flag", 32'({busy, done}), 32'b00);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        $display("txn 999 aborted: %0d done pulses after reset", nd);
        check("abort_nodone", 32'(nd), 32'd0);
        do_start(16'd999);
        wait_done(c, nb);
        $display("txn 999: done at cycle %0d, digits=%h oe=%b", c, digits, digit_oe);
        check("lat_999", 32'(c), 32'd17);
        check("dig_999", 32'(digits), 32'h00999);
        check("oe_999",  32'(digit_oe), 32'b00111);

        // 6. four-digit instance overflows on 12345
        do_start(16'd12345);
        wait_done(c, nb);
        $display("txn 12345: d5=%h d4=%h ovf4=%b oe4=%b", digits, digits4, ovf4, digit_oe4);
        check("d5_12345",  32'(digits), 32'h12345);
        check("ovf5_12345", 32'(ovf), 32'd0);
        check("d4_12345",  32'(digits4), 32'h2345);
        check("ovf4_12345", 32'(ovf4), 32'd1);
        check("oe4_12345", 32'(digit_oe4), 32'b1111);

`ifdef BCD_SIGNED_EN
        do_start(16'h8000);
        wait_done(c, nb);
        $display("txn 8000: digits=%h neg=%b oe=%b", digits, neg, digit_oe);
        check("dig_8000", 32'(digits), 32'h32768);
        check("neg_8000", 32'(neg), 32'd1);
        check("lat_8000", 32'(c), 32'd17);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by %0t want finish", $time);
        $fatal(1, "timeout");
    end

endmodule
